// File: rtl/ps_cmpt_encoder.sv
// Compute-instruction encoder: packs ALU/MUL/SHF descriptors into the
// 21-bit compute field plus float bit and queues them in a small FIFO.
module ps_cmpt_encoder #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enc_vld,
  output logic        enc_rdy,
  input  logic [1:0]  enc_unit,
  input  logic        enc_float,
  input  logic [1:0]  enc_cls,
  input  logic [2:0]  alu_sc1,
  input  logic [1:0]  alu_sc2,
  input  logic        mul_otreg,
  input  logic [3:0]  mul_dtsts,
  input  logic [1:0]  mul_sc,
  input  logic [3:0]  enc_rn,
  input  logic [3:0]  enc_rx,
  input  logic [3:0]  enc_ry,
  output logic        inst_vld,
  input  logic        inst_rdy,
  output logic [20:0] inst_cmpt,
  output logic        inst_float,
  output logic [7:0]  enc_cnt,
  output logic        err_ill,
  input  logic        err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [21:0]   mem_q [DEPTH];

  logic [20:0] cmpt;
  logic        accept, legal, push, pop;

  assign enc_rdy = (count_q < CW'(DEPTH)) & ~rst;
  assign accept  = enc_vld & enc_rdy;
  assign legal   = (enc_unit != 2'b11);
  assign push    = accept & legal;
  assign inst_vld = (count_q != '0);
  assign pop     = inst_vld & inst_rdy;

  always_comb begin
    cmpt = '0;
    case (enc_unit)
      2'b00: begin
        cmpt[20:19] = 2'b00;
        cmpt[18:17] = enc_cls;
        cmpt[16]    = alu_sc2[1];
        cmpt[15:13] = alu_sc1;
        cmpt[12]    = alu_sc2[0];
        cmpt[11:8]  = enc_rn;
        cmpt[7:4]   = enc_rx;
        cmpt[3:0]   = alu_sc2[1] ? 4'd0 : enc_ry;
      end
      2'b01: begin
        cmpt[20:19] = 2'b01;
        cmpt[18:17] = enc_cls;
        cmpt[16]    = mul_otreg;
        cmpt[15:12] = mul_dtsts;
        cmpt[11:8]  = mul_otreg ? 4'd0 : enc_rn;
        // rx survives for multiply classes or an MRF-targeting op other than sc=11
        if ((enc_cls != 2'b00) || (mul_otreg && (mul_sc != 2'b11)))
          cmpt[7:4] = enc_rx;
        cmpt[3:0]   = (enc_cls != 2'b00) ? enc_ry : {2'b00, mul_sc};
      end
      2'b10: begin
        cmpt[20:19] = 2'b10;
        cmpt[16:15] = enc_cls;
        cmpt[11:8]  = enc_rn;
        cmpt[7:4]   = enc_rx;
        cmpt[3:0]   = enc_cls[1] ? 4'd0 : enc_ry;
      end
      default: cmpt = '0;
    endcase
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
      cnt_d    = cnt_q + 8'd1;
    end
    if (pop)
      rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (accept && !legal)
      err_d = 1'b1;
    else if (err_clr)
      err_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      cnt_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Storage needs no reset: the head is masked by inst_vld
  always_ff @(posedge clk) begin
    if (push)
      mem_q[wr_ptr_q] <= {enc_float, cmpt};
  end

  assign inst_cmpt  = inst_vld ? mem_q[rd_ptr_q][20:0] : 21'd0;
  assign inst_float = inst_vld ? mem_q[rd_ptr_q][21] : 1'b0;
  assign enc_cnt    = cnt_q;
  assign err_ill    = err_q;

endmodule

// File: tb/tb_ps_cmpt_encoder.sv
// Bench for ps_cmpt_encoder: directed vectors plus random traffic
// against a queue-based reference model.
module tb_ps_cmpt_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enc_vld = 1'b0;
  logic        enc_rdy;
  logic [1:0]  enc_unit = '0;
  logic        enc_float = 1'b0;
  logic [1:0]  enc_cls = '0;
  logic [2:0]  alu_sc1 = '0;
  logic [1:0]  alu_sc2 = '0;
  logic        mul_otreg = 1'b0;
  logic [3:0]  mul_dtsts = '0;
  logic [1:0]  mul_sc = '0;
  logic [3:0]  enc_rn = '0;
  logic [3:0]  enc_rx = '0;
  logic [3:0]  enc_ry = '0;
  logic        inst_vld;
  logic        inst_rdy = 1'b0;
  logic [20:0] inst_cmpt;
  logic        inst_float;
  logic [7:0]  enc_cnt;
  logic        err_ill;
  logic        err_clr = 1'b0;

  int checks = 0;
  int failures = 0;

  int m_q[$];
  int m_cnt = 0;
  int m_err = 0;

  always #5 clk = ~clk;

  ps_cmpt_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .enc_vld(enc_vld), .enc_rdy(enc_rdy),
    .enc_unit(enc_unit), .enc_float(enc_float),
    .enc_cls(enc_cls), .alu_sc1(alu_sc1), .alu_sc2(alu_sc2),
    .mul_otreg(mul_otreg), .mul_dtsts(mul_dtsts), .mul_sc(mul_sc),
    .enc_rn(enc_rn), .enc_rx(enc_rx), .enc_ry(enc_ry),
    .inst_vld(inst_vld), .inst_rdy(inst_rdy),
    .inst_cmpt(inst_cmpt), .inst_float(inst_float),
    .enc_cnt(enc_cnt), .err_ill(err_ill), .err_clr(err_clr)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ref_enc();
    int u, c, r, x, y, s;
    u = enc_unit; c = enc_cls;
    r = enc_rn; x = enc_rx; y = enc_ry; s = mul_sc;
    if (u == 0)
      return c * (1 << 17) + alu_sc2[1] * (1 << 16) + alu_sc1 * (1 << 13)
           + alu_sc2[0] * (1 << 12) + r * 256 + x * 16
           + (alu_sc2[1] ? 0 : y);
    if (u == 1)
      return (1 << 19) + c * (1 << 17) + mul_otreg * (1 << 16)
           + mul_dtsts * (1 << 12) + (mul_otreg ? 0 : r) * 256
           + ((c != 0 || (mul_otreg && s != 3)) ? x : 0) * 16
           + ((c != 0) ? y : s);
    return (1 << 20) + c * (1 << 15) + r * 256 + x * 16
         + ((c >= 2) ? 0 : y);
  endfunction

  task automatic check_state(input string tag);
    int head;
    head = (m_q.size() > 0) ? m_q[0] : 0;
    chk({tag, ".rdy"}, 32'(enc_rdy), 32'(m_q.size() < DEPTH));
    chk({tag, ".vld"}, 32'(inst_vld), 32'(m_q.size() > 0));
    chk({tag, ".head"}, {10'd0, inst_float, inst_cmpt}, head);
    chk({tag, ".cnt"}, 32'(enc_cnt), m_cnt % 256);
    chk({tag, ".err"}, 32'(err_ill), m_err);
  endtask

  // Inputs are already applied; advance one edge and update the model
  task automatic cycle(input string tag);
    bit acc, pp, ill;
    int e;
    acc = enc_vld && (m_q.size() < DEPTH);
    pp  = (m_q.size() > 0) && inst_rdy;
    ill = acc && (enc_unit == 2'b11);
    e   = enc_float * (1 << 21) + ref_enc();
    @(posedge clk);
    if (pp) void'(m_q.pop_front());
    if (acc && !ill) begin
      m_q.push_back(e);
      m_cnt = (m_cnt + 1) % 256;
    end
    if (ill) m_err = 1;
    else if (err_clr) m_err = 0;
    @(negedge clk);
    check_state(tag);
  endtask

  task automatic rnd_fields(input bit legal_only);
    enc_unit  = legal_only ? 2'($urandom_range(0, 2)) : 2'($urandom);
    enc_float = 1'($urandom);
    enc_cls   = 2'($urandom);
    alu_sc1   = 3'($urandom);
    alu_sc2   = 2'($urandom);
    mul_otreg = 1'($urandom);
    mul_dtsts = 4'($urandom);
    mul_sc    = 2'($urandom);
    enc_rn    = 4'($urandom);
    enc_rx    = 4'($urandom);
    enc_ry    = 4'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_q.delete();
    m_cnt = 0;
    m_err = 0;
    chk("rst.vld", 32'(inst_vld), 0);
    chk("rst.cmpt", 32'(inst_cmpt), 0);
    chk("rst.cnt", 32'(enc_cnt), 0);
    chk("rst.rdy", 32'(enc_rdy), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_state("rel");
  endtask

  initial begin
    rst = 1'b1;
    @(negedge clk);
    do_reset();

    // ALU directed
    inst_rdy = 0; enc_vld = 1;
    enc_unit = 2'b00; enc_cls = 2'b01; alu_sc1 = 3'b010; alu_sc2 = 2'b00;
    enc_rn = 3; enc_rx = 1; enc_ry = 2; enc_float = 1;
    cycle("alu");
    chk("alu.cmpt", 32'(inst_cmpt), 32'h024312);
    chk("alu.flt", 32'(inst_float), 1);
    chk("alu.cnt", 32'(enc_cnt), 1);
    enc_vld = 0; inst_rdy = 1;
    cycle("alu.pop");

    // MUL directed
    inst_rdy = 0; enc_vld = 1; enc_float = 0;
    enc_unit = 2'b01; enc_cls = 2'b00; mul_otreg = 1; mul_dtsts = 4'b1010;
    mul_sc = 2'b01; enc_rn = 5; enc_rx = 6; enc_ry = 0;
    cycle("mul");
    chk("mul.cmpt", 32'(inst_cmpt), 32'h09A061);
    enc_vld = 0; inst_rdy = 1;
    cycle("mul.pop");

    // SHF directed
    inst_rdy = 0; enc_vld = 1;
    enc_unit = 2'b10; enc_cls = 2'b10; enc_rn = 7; enc_rx = 8; enc_ry = 9;
    cycle("shf");
    chk("shf.cmpt", 32'(inst_cmpt), 32'h110780);
    enc_vld = 0; inst_rdy = 1;
    cycle("shf.pop");
    cycle("empty");

    // Backpressure: five pushes into a four-entry queue
    inst_rdy = 0;
    for (int i = 0; i < 5; i++) begin
      rnd_fields(1);
      enc_vld = 1;
      cycle("bp.push");
    end
    chk("bp.full", 32'(enc_rdy), 0);
    enc_vld = 0; inst_rdy = 1;
    for (int i = 0; i < 5; i++) cycle("bp.drain");

    // Illegal unit handling
    inst_rdy = 0; enc_vld = 1; enc_unit = 2'b11;
    cycle("ill");
    chk("ill.err", 32'(err_ill), 1);
    chk("ill.vld", 32'(inst_vld), 0);
    err_clr = 1;
    cycle("ill.clr");
    chk("ill.setwins", 32'(err_ill), 1);
    enc_vld = 0;
    cycle("clr");
    chk("clr.err", 32'(err_ill), 0);
    err_clr = 0;

    // Reset with three queued entries
    do_reset();
    enc_vld = 1; inst_rdy = 0;
    for (int i = 0; i < 3; i++) begin
      rnd_fields(1);
      cycle("pre.rst");
    end
    enc_vld = 0;
    do_reset();

    // 256 legal pushes wrap enc_cnt
    enc_vld = 1; inst_rdy = 1;
    for (int i = 0; i < 256; i++) begin
      rnd_fields(1);
      cycle("wrap");
    end
    chk("wrap.cnt", 32'(enc_cnt), 0);

    // Random traffic
    for (int i = 0; i < 800; i++) begin
      rnd_fields(0);
      if ($urandom_range(0, 7) != 0 && enc_unit == 2'b11)
        enc_unit = 2'($urandom_range(0, 2));
      enc_vld  = 1'($urandom);
      inst_rdy = ($urandom_range(0, 3) != 0);
      err_clr  = ($urandom_range(0, 9) == 0);
      cycle("rnd");
    end
    enc_vld = 0; err_clr = 0; inst_rdy = 1;
    for (int i = 0; i < DEPTH + 1; i++) cycle("final");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps_cmpt_encoder.md
# ps_cmpt_encoder

Compute-instruction encoder: accepts a decomposed compute-operation descriptor (unit, classification, sub-classification, register addresses, float flag) over a valid/ready handshake. It packs the descriptor into the 21-bit compute field plus float bit consumed by the compute-instruction decoder, and queues it in a small output FIFO. It sits between the program-sequencer test/instruction-generation path and instruction memory or the decoder input, and produces bit-exact encodings that round-trip through the decoder.

## Interface

- DEPTH, 4, output FIFO entries (power of two, ≥2).
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- enc_vld  in  1  descriptor valid.
- enc_rdy  out  1  encoder can accept a descriptor.
- enc_unit  in  2  00 ALU, 01 MUL, 10 SHF, 11 illegal.
- enc_float  in  1  floating-point flag (becomes instruction bit 26).
- enc_cls  in  2  ALU higher class / MUL class / SHF class.
- alu_sc1  in  3  ALU sub-class 1.
- alu_sc2  in  2  ALU sub-class 2 ({bit16, bit12}).
- mul_otreg  in  1  MUL output select, 1 = MRF, 0 = Rn.
- mul_dtsts  in  4  MUL data status.
- mul_sc  in  2  MUL sub-class.
- enc_rn, enc_rx, enc_ry  in  4 each  write, input-1, input-2 register addresses.
- inst_vld  out  1  FIFO head valid.
- inst_rdy  in  1  consumer takes head.
- inst_cmpt  out  21  encoded compute field (instruction bits 25:5).
- inst_float  out  1  encoded bit 26.
- enc_cnt  out  8  count of legal descriptors encoded, wraps.
- err_ill  out  1  sticky illegal-unit flag.
- err_clr  in  1  clears err_ill.

## Operation

- Accept = enc_vld & enc_rdy. enc_rdy = (fifo count < DEPTH) & !rst. It depends only on registered count, with no pop pass-through.
- Packing (c = inst_cmpt). All bits not listed are 0.
  - ALU: c[20:19]=00, c[18:17]=cls, c[16]=alu_sc2[1], c[15:13]=alu_sc1, c[12]=alu_sc2[0], c[11:8]=rn, c[7:4]=rx, c[3:0]= alu_sc2[1] ? 0 : ry.
  - MUL: c[20:19]=01, c[18:17]=cls, c[16]=otreg, c[15:12]=dtsts, c[11:8]= otreg ? 0 : rn. c[7:4]= (cls≠0 | (otreg & sc≠11)) ? rx : 0. c[3:0]= cls≠0 ? ry : {00,sc}. With cls≠0, mul_sc is ignored.
  - SHF: c[20:19]=10, c[16:15]=cls, c[11:8]=rn, c[7:4]=rx, c[3:0]= cls[1] ? 0 : ry.
- Legal accept: push {enc_float, c} into the FIFO and increment enc_cnt mod 256.
- Illegal unit (11): the descriptor is consumed, nothing is pushed, err_ill is set, and enc_cnt is unchanged.
- err_ill clears on err_clr. If an illegal accept and err_clr occur in the same cycle, set wins.
- FIFO: circular, DEPTH entries, wr/rd pointers wrap at DEPTH. Count range is 0..DEPTH.
- Pop = inst_vld & inst_rdy. A simultaneous push and pop leaves count unchanged.
- inst_cmpt/inst_float show the head entry when inst_vld=1, else 0.

## Timing

- Reset values: count 0, pointers 0, inst_vld 0, inst_cmpt 0, inst_float 0, enc_cnt 0, err_ill 0. enc_rdy is 0 while rst is high and 1 on the first cycle after release.
- Latency: a descriptor accepted at edge N appears on inst_vld/inst_cmpt after edge N, i.e. usable in cycle N+1. This is one cycle with FIFO empty; there is no combinational path from enc_* to inst_*.
- Throughput: one descriptor per cycle while not full, one pop per cycle.
- Full: enc_rdy drops in the cycle after count reaches DEPTH. A pop in a full cycle re-raises enc_rdy on the next cycle.
- Empty with inst_rdy high: no pop, count stays 0.
- Reset asserted mid-stream flushes the FIFO immediately (async). In-flight entries are lost.
- The consumer holds inst_cmpt stable until it pops. The encoder keeps the head unchanged while inst_vld & !inst_rdy.

## Test plan

- ALU: cls=01, sc1=010, sc2=00, rn=3, rx=1, ry=2, float=1 -> next cycle inst_cmpt=0x024312, inst_float=1, enc_cnt=1.
- MUL: cls=00, otreg=1, dtsts=1010, sc=01, rn=5, rx=6 -> inst_cmpt=0x09A061 (rn suppressed, rx kept).
- SHF: cls=10, rn=7, rx=8, ry=9 -> inst_cmpt=0x110780 (ry suppressed).
- Backpressure: inst_rdy=0, push 5 legal descriptors with DEPTH=4 -> enc_rdy low after the 4th. Release inst_rdy -> entries pop in order, none lost or duplicated.
- Illegal: enc_unit=11 accepted -> no inst_vld, err_ill=1, enc_cnt unchanged. Repeat with err_clr in the same cycle -> err_ill stays 1. err_clr alone -> 0.
- Reset with 3 queued entries -> inst_vld=0, inst_cmpt=0, enc_cnt=0 immediately. 256 legal pushes -> enc_cnt wraps to 0.
